// File: rtl/simplez_pkg.sv
// Shared Simplez constants and the program loader's state encoding.
// Loader checksum checking is selected by SIMPLEZ_LOADER_CSUM_EN in simplez_loader.
package simplez_pkg;

  localparam int SIMPLEZ_AW = 9;
  localparam int SIMPLEZ_DW = 12;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CNT_H = 3'd1,
    ST_CNT_L = 3'd2,
    ST_W_HI  = 3'd3,
    ST_W_LO  = 3'd4,
    ST_CSUM  = 3'd5,
    ST_RUN   = 3'd6,
    ST_ERROR = 3'd7
  } loader_state_e;

  // States that belong to a frame being received.
  function automatic logic in_frame(loader_state_e s);
    return (s == ST_CNT_H) || (s == ST_CNT_L) || (s == ST_W_HI) ||
           (s == ST_W_LO) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle watchdog for the program loader; TIMEOUT = 0 disables it.
module loader_timeout #(
  parameter int TIMEOUT = 1_200_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

      logic [CW-1:0] idle_cnt;

      // Counts idle clocks since the last byte, saturating at the limit.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          idle_cnt <= '0;
        end else if (clear || !enable) begin
          idle_cnt <= '0;
        end else if (idle_cnt != LIMIT) begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end

      assign expired = enable && (idle_cnt == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/simplez_loader.sv
// Serial program loader: frames bytes into 12-bit RAM words and holds the CPU in reset
// until a frame is accepted. Define SIMPLEZ_LOADER_CSUM_EN to check the XOR checksum.
module simplez_loader
  import simplez_pkg::*;
#(
  parameter int AW      = SIMPLEZ_AW,
  parameter int DW      = SIMPLEZ_DW,
  parameter int TIMEOUT = 1_200_000
) (
  input  logic          clk,
  input  logic          rstn,
  // rx_valid/rx_data: one byte is consumed on every clock where rx_valid is high;
  // there is no backpressure, so the loader accepts a byte on every cycle.
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          cpu_rstn,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    state_dbg
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << AW;

  loader_state_e state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [AW:0]   addr_q, addr_d;
  logic [AW:0]   addr_inc;
  logic [3:0]    nib_q, nib_d;
  logic          wr_en_d;
  logic [AW-1:0] wr_addr_d;
  logic [DW-1:0] wr_data_d;
  logic [15:0]   count_full;
  logic          count_bad;
  logic          start_frame;
  logic          frame_active;
  logic          csum_ok;
  logic          expired;

  assign frame_active = in_frame(state_q);
  assign start_frame  = rx_valid && (rx_data == SYNC_BYTE) &&
                        ((state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_ERROR));
  assign count_full   = {cnt_q[15:8], rx_data};
  assign count_bad    = (count_full == 16'd0) || ({1'b0, count_full} > MAX_WORDS);
  assign addr_inc     = addr_q + 1'b1;

  loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (rx_valid),
    .enable (frame_active),
    .expired(expired)
  );

`ifdef SIMPLEZ_LOADER_CSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       csum_byte;

  // Count and word bytes feed the checksum; the sync byte restarts it.
  assign csum_byte = rx_valid && frame_active && (state_q != ST_CSUM);

  always_comb begin
    csum_d = csum_q;
    if (start_frame) begin
      csum_d = 8'h00;
    end else if (csum_byte) begin
      csum_d = csum_q ^ rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum_ok = (rx_data == csum_q);
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    nib_d     = nib_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;

    case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start_frame) begin
          state_d = ST_CNT_H;
        end
      end
      ST_CNT_H: begin
        if (rx_valid) begin
          cnt_d[15:8] = rx_data;
          state_d     = ST_CNT_L;
        end
      end
      ST_CNT_L: begin
        if (rx_valid) begin
          cnt_d[7:0] = rx_data;
          addr_d     = '0;
          state_d    = count_bad ? ST_ERROR : ST_W_HI;
        end
      end
      ST_W_HI: begin
        if (rx_valid) begin
          if (rx_data[7:4] != 4'h0) begin
            state_d = ST_ERROR;
          end else begin
            nib_d   = rx_data[3:0];
            state_d = ST_W_LO;
          end
        end
      end
      ST_W_LO: begin
        if (rx_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q[AW-1:0];
          wr_data_d = DW'({nib_q, rx_data});
          addr_d    = addr_inc;
          // The extra address bit lets a full 2^AW-word frame reach its count.
          state_d   = (17'(addr_inc) == {1'b0, cnt_q}) ? ST_CSUM : ST_W_HI;
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          state_d = csum_ok ? ST_RUN : ST_ERROR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_active && !rx_valid && expired) begin
      state_d = ST_ERROR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 16'd0;
      addr_q   <= '0;
      nib_q    <= 4'h0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_rstn <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      nib_q    <= nib_d;
      wr_en    <= wr_en_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      cpu_rstn <= (state_d == ST_RUN);
      busy     <= in_frame(state_d);
      done     <= (state_d == ST_RUN);
      err      <= (state_d == ST_ERROR);
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_simplez_loader.sv
// Bench for simplez_loader: per-cycle compare against a frame-level byte model,
// plus directed literal checks. Honours SIMPLEZ_LOADER_CSUM_EN like the design.
module tb_simplez_loader;

  localparam int AW      = 9;
  localparam int DW      = 12;
  localparam int TIMEOUT = 100;

  logic          clk;
  logic          rstn;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          cpu_rstn;
  logic          busy;
  logic          done;
  logic          err;
  logic [2:0]    state_dbg;

  simplez_loader #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_rstn (cpu_rstn),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame is interpreted by byte position: 0,1 = count; then 2N word bytes; then checksum.
  logic [AW+DW-1:0] exp_q[$];
  bit               model_live = 0;
  bit               m_active = 0, m_done = 0, m_err = 0, m_we = 0;
  int               m_pos = 0, m_n = 0, m_idle = 0;
  logic [7:0]       m_x = 8'h00, m_hi = 8'h00;

  always @(posedge clk) begin
    m_we = 0;
    if (!rstn) begin
      model_live = 1;
      m_active = 0; m_done = 0; m_err = 0; m_idle = 0;
      exp_q.delete();
    end else if (rx_valid) begin
      m_idle = 0;
      if (!m_active) begin
        if (rx_data == 8'hA5) begin
          m_active = 1; m_pos = 0; m_x = 8'h00; m_done = 0; m_err = 0;
        end
      end else begin
        if (m_pos == 0) begin
          m_n = int'(rx_data) * 256;
          m_x ^= rx_data;
        end else if (m_pos == 1) begin
          m_n += int'(rx_data);
          m_x ^= rx_data;
          if (m_n == 0 || m_n > (1 << AW)) begin m_active = 0; m_err = 1; end
        end else if (m_pos < 2 + 2 * m_n) begin
          m_x ^= rx_data;
          if ((m_pos - 2) % 2 == 0) begin
            if (rx_data > 8'h0F) begin m_active = 0; m_err = 1; end
            else m_hi = rx_data;
          end else begin
            exp_q.push_back({AW'((m_pos - 2) / 2), m_hi[3:0], rx_data});
            m_we = 1;
          end
        end else begin
`ifdef SIMPLEZ_LOADER_CSUM_EN
          if (rx_data == m_x) begin m_active = 0; m_done = 1; end
          else begin m_active = 0; m_err = 1; end
`else
          m_active = 0; m_done = 1;
`endif
        end
        m_pos++;
      end
    end else if (m_active) begin
      m_idle++;
      if (m_idle > TIMEOUT) begin m_active = 0; m_err = 1; end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [AW-1:0] wl_addr[$];
  logic [DW-1:0] wl_data[$];

  always @(negedge clk) begin
    if (model_live) begin
      check("wr_en", wr_en, m_we);
      if (wr_en) begin
        wl_addr.push_back(wr_addr);
        wl_data.push_back(wr_data);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write addr=%0h data=%0h @%0t", wr_addr, wr_data, $time);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e[AW+DW-1:DW]);
          check("wr_data", wr_data, e[DW-1:0]);
        end
      end else if (m_we && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
      check("done", done, m_done);
      check("err", err, m_err);
      check("busy", busy, m_active);
      check("cpu_rstn", cpu_rstn, m_done);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic clear_log();
    wl_addr.delete();
    wl_data.delete();
  endtask

  logic [7:0] fq[$];

  task automatic random_frame();
    int mode, n, gap, cut;
    logic [7:0] x, b, lo;
    fq.delete();
    mode = $urandom_range(0, 11);
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom_range(0, 255));
      fq.push_back((b == 8'hA5) ? 8'h00 : b);
    end
    fq.push_back(8'hA5);
    n = (mode == 0) ? 0 : (mode == 1) ? $urandom_range(513, 600) : $urandom_range(1, 6);
    fq.push_back(8'(n >> 8));
    fq.push_back(8'(n));
    x = 8'(n >> 8) ^ 8'(n);
    if (mode > 1) begin
      for (int i = 0; i < n; i++) begin
        b  = (mode == 2 && i == n - 1) ? 8'(8'h10 | $urandom_range(0, 239)) : 8'($urandom_range(0, 15));
        lo = 8'($urandom_range(0, 255));
        fq.push_back(b); fq.push_back(lo);
        x = x ^ b ^ lo;
      end
      if (mode == 3) x = x ^ (8'h01 << $urandom_range(0, 7));
      fq.push_back(x);
    end
    cut = (mode == 4) ? $urandom_range(1, fq.size() - 1) : fq.size();
    for (int i = 0; i < cut; i++) begin
      send_byte(fq[i]);
      gap = ($urandom_range(0, 24) == 0) ? $urandom_range(97, 104) : $urandom_range(0, 2);
      if ($urandom_range(0, 3) != 0) gap = 0;
      idle_cycles(gap);
    end
    if (mode == 4) do_reset();
    idle_cycles($urandom_range(0, 3));
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int k;
    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle_cycles(3);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_cpu_rstn", cpu_rstn, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rstn = 1'b1;
    idle_cycles(2);

    // XOR of 00 02 01 23 0F FF is D0.
    clear_log();
    send_byte(8'h55);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h0F); send_byte(8'hFF);
    send_byte(8'hD0);
    check("f1_done", done, 1);
    check("f1_cpu_rstn", cpu_rstn, 1);
    check("f1_nwrites", wl_addr.size(), 2);
    if (wl_addr.size() == 2) begin
      check("f1_addr0", wl_addr[0], 9'h000);
      check("f1_data0", wl_data[0], 12'h123);
      check("f1_addr1", wl_addr[1], 9'h001);
      check("f1_data1", wl_data[1], 12'hFFF);
    end
    idle_cycles(2);

    clear_log();
    send_byte(8'hA5);
    check("resync_done", done, 0);
    check("resync_cpu_rstn", cpu_rstn, 0);
    check("resync_busy", busy, 1);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h0F); send_byte(8'hFF);
    send_byte(8'h00);
`ifdef SIMPLEZ_LOADER_CSUM_EN
    check("f2_err", err, 1);
    check("f2_cpu_rstn", cpu_rstn, 0);
`else
    check("f2_done", done, 1);
    check("f2_cpu_rstn", cpu_rstn, 1);
`endif
    check("f2_nwrites", wl_addr.size(), 2);
    idle_cycles(2);

    clear_log();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    check("cnt0_err", err, 1);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
    check("cnt513_err", err, 1);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h1F);
    check("hinib_err", err, 1);
    idle_cycles(2);
    check("bad_nwrites", wl_addr.size(), 0);

    // Full 512-word frame: addresses must run 0..511 without wrapping early.
    clear_log();
    begin
      logic [7:0] x, b, lo;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      x = 8'h02;
      for (int i = 0; i < 512; i++) begin
        b = 8'($urandom_range(0, 15)); lo = 8'($urandom_range(0, 255));
        send_byte(b); send_byte(lo);
        x = x ^ b ^ lo;
      end
      send_byte(x);
    end
    check("full_done", done, 1);
    check("full_nwrites", wl_addr.size(), 512);
    if (wl_addr.size() == 512) check("full_last_addr", wl_addr[511], 9'd511);

    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (err) begin k = i; break; end
    end
    check("timeout_cycles", k, 101);

    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h01);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("mid_wr_en", wr_en, 0);
    check("mid_wr_addr", wr_addr, 0);
    check("mid_wr_data", wr_data, 0);
    check("mid_cpu_rstn", cpu_rstn, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_err", err, 0);
    check("mid_state", state_dbg, 0);
    rstn = 1'b1;
    idle_cycles(2);

    for (int f = 0; f < 250; f++) random_frame();

    idle_cycles(4);
    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
